// File: rtl/riscv_instr_encoder_if.sv
// rtl/riscv_instr_encoder_if.sv - field-set input and instruction-word output streams of the encoder
interface riscv_instr_encoder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       fmt;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;

    // Producer of field sets and consumer of encoded words
    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_word
    );

    // The encoder itself
    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_word
    );
endinterface

// File: rtl/riscv_instr_encoder.sv
// rtl/riscv_instr_encoder.sv - RV32I field packer with output FIFO and flush terminator (optional ENC_ERR_CNT_EN)
module riscv_instr_encoder #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    riscv_instr_encoder_if.slave bus,
    input  logic               flush,
    output logic               enc_err,
    output logic               done,
    output logic [PTR_W:0]     count
`ifdef ENC_ERR_CNT_EN
    ,
    output logic [15:0]        err_cnt
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TERM  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_enc_err;
    logic               r_done;
    logic [WIDTH-1:0]   w_word;
    logic               w_reject;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_in_ready;
    logic               w_out_valid;
    logic [WIDTH-1:0]   w_out_word;

    // Pack the presented field set into an RV32I word and flag illegal sets
    always_comb begin
        w_word   = '0;
        w_reject = 1'b0;
        case (bus.fmt)
            3'd0: w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd1: w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd2: w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            3'd3: begin
                w_word   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.imm[4:1], bus.imm[11], bus.opcode};
                w_reject = bus.imm[0];
            end
            3'd4: w_word = {bus.imm[31:12], bus.rd, bus.opcode};
            3'd5: begin
                w_word   = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                            bus.rd, bus.opcode};
                w_reject = bus.imm[0];
            end
            default: w_reject = 1'b1;
        endcase
    end

    // Handshake qualifiers; the terminator is produced by the FSM, never stored
    always_comb begin
        w_in_ready  = !rst && (r_state == ST_RUN) && (r_count < FULL_CNT);
        w_accept    = bus.in_valid && w_in_ready;
        w_push      = w_accept && !w_reject;
        w_out_valid = (r_count != '0) || (r_state == ST_TERM);
        w_out_word  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
        w_pop       = (r_count != '0) && bus.out_ready;
    end

    // Next-state logic for the flush sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (flush) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_count == '0) w_state_nxt = ST_TERM;
            ST_TERM:  if (bus.out_ready) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // State, pointers, occupancy and the one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_enc_err <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_enc_err <= w_accept && w_reject;
            r_done    <= (r_state == ST_TERM) && bus.out_ready;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Word storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

`ifdef ENC_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of rejected field sets
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_reject && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_word  = w_out_word;
    assign enc_err       = r_enc_err;
    assign done          = r_done;
    assign count         = r_count;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// tb/tb_riscv_instr_encoder.sv - directed self-checking bench for riscv_instr_encoder
module tb_riscv_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        enc_err;
    logic        done;
    logic [2:0]  count;
`ifdef ENC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif
    int total = 0;
    int bad   = 0;

    riscv_instr_encoder_if #(.WIDTH(32)) bus ();

    riscv_instr_encoder #(.WIDTH(32), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .flush   (flush),
        .enc_err (enc_err),
        .done    (done),
        .count   (count)
`ifdef ENC_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
        @(negedge clk);
        bus.fmt      = f;
        bus.opcode   = op;
        bus.rd       = d;
        bus.rs1      = s1;
        bus.rs2      = s2;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.imm      = im;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
        present(f, op, d, s1, s2, f3, f7, im);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Encode-and-pop check for a single word with out_ready held high
    task automatic one_word(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_word"}, bus.out_word, exp);
        tick();
        chk({tag, "_popped"}, 32'(count), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0;
        bus.rs2 = '0; bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
        tick(); tick();
        chk("in_ready_in_rst", 32'(bus.in_ready), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_word", bus.out_word, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_enc_err", 32'(enc_err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Format encodings, one at a time with downstream ready
        bus.out_ready = 1'b1;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
        one_word("r_add", 32'h002081B3);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        one_word("i_addi", 32'h00500093);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        one_word("s_sw", 32'h0020A423);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
        one_word("b_beq", 32'hFE000EE3);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        one_word("u_lui", 32'h123452B7);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        one_word("j_jal", 32'h008000EF);

        // Rejected field sets: misaligned J offset, illegal format
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        chk("jodd_err", 32'(enc_err), 32'd1);
        chk("jodd_count", 32'(count), 32'd0);
        chk("jodd_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("jodd_err_pulse", 32'(enc_err), 32'd0);
        send(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        chk("fmt7_err", 32'(enc_err), 32'd1);
        chk("fmt7_count", 32'(count), 32'd0);
        tick();
        chk("fmt7_err_pulse", 32'(enc_err), 32'd0);
`ifdef ENC_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'd2);
`endif

        // Backpressure: four addi x1,x0,k words fill the FIFO, fifth waits
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        present(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        chk("full_blocked", 32'(count), 32'd4);
        chk("full_hold", bus.out_word, 32'h00100093);
        @(negedge clk); bus.out_ready = 1'b1;
        tick();
        chk("drain1_word", bus.out_word, 32'h00200093);
        chk("drain1_count", 32'(count), 32'd3);
        tick();
        bus.in_valid = 1'b0;
        chk("drain2_word", bus.out_word, 32'h00300093);
        chk("drain2_count", 32'(count), 32'd3);
        tick();
        chk("drain3_word", bus.out_word, 32'h00400093);
        tick();
        chk("drain4_word", bus.out_word, 32'h00500093);
        chk("drain4_count", 32'(count), 32'd1);
        tick();
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Flush: two words, then terminator, then done
        bus.out_ready = 1'b0;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk); flush = 1'b1;
        tick();
        chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fl_word0", bus.out_word, 32'h002081B3);
        @(negedge clk); flush = 1'b0; bus.out_ready = 1'b1;
        tick();
        chk("fl_word1", bus.out_word, 32'h00500093);
        chk("fl_in_ready1", 32'(bus.in_ready), 32'd0);
        tick();
        chk("fl_count0", 32'(count), 32'd0);
        tick();
        chk("term_valid", 32'(bus.out_valid), 32'd1);
        chk("term_word", bus.out_word, 32'h0);
        chk("term_in_ready", 32'(bus.in_ready), 32'd0);
        chk("term_no_done", 32'(done), 32'd0);
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("run_in_ready", 32'(bus.in_ready), 32'd1);
        chk("run_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("done_cleared", 32'(done), 32'd0);

        // Flush together with an accept keeps the word; reset mid-DRAIN clears all
        bus.out_ready = 1'b0;
        present(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        flush = 1'b1;
        tick();
        bus.in_valid = 1'b0; flush = 1'b0;
        chk("flacc_count", 32'(count), 32'd1);
        chk("flacc_word", bus.out_word, 32'h123452B7);
        chk("flacc_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk); rst = 1'b1;
        tick();
        @(negedge clk); rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_run", 32'(bus.in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
